// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port synchronous RAM with registered read and optional same-address write bypass
module fifo_ram #(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 4,
   parameter string SSA_EN     = "NO"
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam bit BYPASS = (SSA_EN == "YES");

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  collide;

   // Without bypass a collision naturally returns the pre-write word.
   always_comb begin
      collide   = wr_en && rd_en && (wr_addr == rd_addr);
      rd_data_d = rd_data_q;
      if (rd_en) begin
         if (BYPASS && collide) begin
            rd_data_d = wr_data;
         end else begin
            rd_data_d = mem_q[rd_addr];
         end
      end
   end

   // Array contents are deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_fifo_ram.sv
// tb/tb_fifo_ram.sv - self-checking bench for fifo_ram in both bypass modes
module tb_fifo_ram;

   logic        clk;
   logic        reset;
   logic [31:0] wr_data;
   logic [3:0]  wr_addr;
   logic        wr_en;
   logic [3:0]  rd_addr;
   logic        rd_en;
   logic [31:0] rd_no;
   logic [31:0] rd_yes;

   fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SSA_EN("NO")) dut_no (
      .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_no)
   );

   fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SSA_EN("YES")) dut_yes (
      .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_yes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] no;
      logic [31:0] yes;
      bit          vno;
      bit          vyes;
   } exp_t;

   typedef struct {
      bit          rst;
      bit          we;
      logic [3:0]  wa;
      logic [31:0] wd;
      bit          re;
      logic [3:0]  ra;
      logic [31:0] exp_no;
      logic [31:0] exp_yes;
      bit          chk;
   } vec_t;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mem_m [16];
   bit          known [16];
   exp_t        last;
   exp_t        sb_q [$];
   vec_t        vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle, predict both modes into the scoreboard, then compare after the edge.
   task automatic step(input bit rst, input bit we, input logic [3:0] wa, input logic [31:0] wd,
                       input bit re, input logic [3:0] ra);
      exp_t e;
      exp_t got;
      reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
      if (rst) begin
         e.no = '0; e.yes = '0; e.vno = 1'b1; e.vyes = 1'b1;
      end else if (re) begin
         e.no  = mem_m[ra];
         e.vno = known[ra];
         if (we && wa == ra) begin
            e.yes = wd; e.vyes = 1'b1;
         end else begin
            e.yes = mem_m[ra]; e.vyes = known[ra];
         end
      end else begin
         e = last;
      end
      if (!rst && we) begin
         mem_m[wa] = wd;
         known[wa] = 1'b1;
      end
      last = e;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      if (got.vno)  check("sb_no", rd_no, got.no);
      if (got.vyes) check("sb_yes", rd_yes, got.yes);
   endtask

   initial begin
      logic [3:0] ptr;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
      last.no = '0; last.yes = '0; last.vno = 1'b0; last.vyes = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_m[i] = '0;
         known[i] = 1'b0;
      end

      //                rst  we  wa     wd             re  ra     exp_no         exp_yes        chk
      vecs.push_back('{1'b1,1'b1,4'd3, 32'hDEADBEEF, 1'b0,4'd0, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b1,1'b1,4'd3, 32'hDEADBEEF, 1'b0,4'd0, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b0,1'b1,4'd3, 32'h12345678, 1'b0,4'd3, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd3, 32'h12345678,  32'h12345678,  1'b1});
      vecs.push_back('{1'b1,1'b1,4'd3, 32'hDEADBEEF, 1'b0,4'd0, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b1,1'b1,4'd3, 32'hDEADBEEF, 1'b1,4'd3, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd3, 32'h12345678,  32'h12345678,  1'b1});
      vecs.push_back('{1'b0,1'b1,4'd5, 32'h55,       1'b0,4'd0, 32'h12345678,  32'h12345678,  1'b1});
      vecs.push_back('{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd5, 32'h55,        32'h55,        1'b1});
      vecs.push_back('{1'b0,1'b1,4'd5, 32'hAA,       1'b0,4'd9, 32'h55,        32'h55,        1'b1});
      vecs.push_back('{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd1, 32'h55,        32'h55,        1'b1});
      vecs.push_back('{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd5, 32'hAA,        32'hAA,        1'b1});
      vecs.push_back('{1'b0,1'b1,4'd7, 32'h11,       1'b0,4'd0, 32'hAA,        32'hAA,        1'b1});
      vecs.push_back('{1'b0,1'b1,4'd7, 32'h22,       1'b1,4'd7, 32'h11,        32'h22,        1'b1});
      vecs.push_back('{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd7, 32'h22,        32'h22,        1'b1});
      vecs.push_back('{1'b0,1'b1,4'd9, 32'h99,       1'b0,4'd0, 32'h22,        32'h22,        1'b1});
      vecs.push_back('{1'b0,1'b1,4'd2, 32'h33,       1'b1,4'd9, 32'h99,        32'h99,        1'b1});
      vecs.push_back('{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd2, 32'h33,        32'h33,        1'b1});

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
         if (vecs[i].chk) begin
            check($sformatf("vec%0d_no", i), rd_no, vecs[i].exp_no);
            check($sformatf("vec%0d_yes", i), rd_yes, vecs[i].exp_yes);
         end
      end

      // Fill then drain every location in order.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 32'(i), 1'b0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'(i));
         check($sformatf("drain%0d", i), rd_no, 32'(i));
      end

      // Caller pointer overflowing from 15 back to 0.
      ptr = 4'd14;
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, ptr, 32'hA0 + 32'(k), 1'b0, 4'd0);
         ptr = ptr + 4'd1;
      end
      ptr = 4'd14;
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, ptr);
         check($sformatf("wrap%0d", k), rd_yes, 32'hA0 + 32'(k));
         ptr = ptr + 4'd1;
      end

      // Random traffic checked only against the scoreboard model.
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(0, 24) == 0, 1'($urandom), 4'($urandom), $urandom,
              1'($urandom), 4'($urandom_range(0, 3) == 0 ? 7 : $urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
